lif_array: RTL

//  Parametrised bank of N_CH leaky integrate-and-fire neurons for the TT LIF demo.

---
 rtl/lif_pkg.sv | 20 ++
 rtl/lif_array_if.sv | 25 ++
 rtl/lif_cell.sv | 76 +++++++
 rtl/lif_array.sv | 72 +++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared constants and helpers for the leaky integrate-and-fire neuron bank.
package lif_pkg;

  localparam int LIF_BETA_SHIFT = 2;
  localparam int LIF_THR_BASE   = 100;
  localparam int LIF_THR_INC    = 16;
  localparam int LIF_REFRAC     = 2;

  // Unsigned add clamped to 2^w-1; valid for w up to 31.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_array_if.sv
// Timestep request/result bundle between the pad wrapper, the neuron bank and the output mux.
interface lif_array_if #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int CW   = $clog2(N_CH + 1)
);
  logic              in_valid;
  logic [N_CH*W-1:0] current;
  logic              adapt_thr;
  logic              adapt_beta;
  logic [N_CH*W-1:0] state;
  logic [N_CH-1:0]   spike;
  logic [CW-1:0]     spike_cnt;
  logic              out_valid;

  modport master (
    output in_valid, current, adapt_thr, adapt_beta,
    input  state, spike, spike_cnt, out_valid
  );

  modport slave (
    input  in_valid, current, adapt_thr, adapt_beta,
    output state, spike, spike_cnt, out_valid
  );
endinterface

// File: rtl/lif_cell.sv
// One LIF channel: membrane state, adaptive threshold and refractory counter.
// fire is combinational and already qualified by step; the parent registers it.
module lif_cell
  import lif_pkg::*;
#(
  parameter int W          = 8,
  parameter int BETA_SHIFT = LIF_BETA_SHIFT,
  parameter int THR_BASE   = LIF_THR_BASE,
  parameter int THR_INC    = LIF_THR_INC,
  parameter int REFRAC     = LIF_REFRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic [W-1:0] current,
  input  logic         adapt_thr,
  input  logic         adapt_beta,
  output logic [W-1:0] state,
  output logic         fire
);

  localparam int RCW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [W-1:0]   state_reg, state_next;
  logic [W-1:0]   thr_reg, thr_next;
  logic [RCW-1:0] rcnt_reg, rcnt_next;
  logic [W-1:0]   leak;
  logic [W-1:0]   v;
  logic           hit;

  always_comb begin
    leak       = adapt_beta ? (state_reg >> (BETA_SHIFT + 1)) : (state_reg >> BETA_SHIFT);
    // state - leak never underflows, so only the add needs saturation.
    v          = W'(sat_add(32'(state_reg - leak), 32'(current), W));
    hit        = (rcnt_reg == '0) && (v >= thr_reg);
    fire       = step && hit;
    state_next = state_reg;
    thr_next   = thr_reg;
    rcnt_next  = rcnt_reg;
    if (step) begin
      if (rcnt_reg != '0) begin
        rcnt_next  = rcnt_reg - 1'b1;
        state_next = '0;
      end else if (hit) begin
        state_next = '0;
        rcnt_next  = RCW'(REFRAC);
      end else begin
        state_next = v;
      end

      // Threshold moves on every step, refractory ones included.
      if (!adapt_thr) begin
        thr_next = W'(THR_BASE);
      end else if (hit) begin
        thr_next = W'(sat_add(32'(thr_reg), 32'(THR_INC), W));
      end else if (thr_reg > W'(THR_BASE)) begin
        thr_next = thr_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      thr_reg   <= W'(THR_BASE);
      rcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      thr_reg   <= thr_next;
      rcnt_reg  <= rcnt_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/lif_array.sv
// Bank of N_CH independent LIF channels advanced together on in_valid;
// registers the spike vector, its popcount and out_valid with one cycle latency.
module lif_array
  import lif_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int W          = 8,
  parameter int BETA_SHIFT = LIF_BETA_SHIFT,
  parameter int THR_BASE   = LIF_THR_BASE,
  parameter int THR_INC    = LIF_THR_INC,
  parameter int REFRAC     = LIF_REFRAC
) (
  input logic        clk,
  input logic        rst_n,
  lif_array_if.slave bus
);

  localparam int CW = $clog2(N_CH + 1);

  logic [N_CH-1:0]   fire_vec;
  logic [N_CH*W-1:0] state_vec;
  logic [N_CH-1:0]   spike_reg;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              out_valid_reg;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : gen_cell
      lif_cell #(
        .W          (W),
        .BETA_SHIFT (BETA_SHIFT),
        .THR_BASE   (THR_BASE),
        .THR_INC    (THR_INC),
        .REFRAC     (REFRAC)
      ) u_cell (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (bus.in_valid),
        .current    (bus.current[gi*W +: W]),
        .adapt_thr  (bus.adapt_thr),
        .adapt_beta (bus.adapt_beta),
        .state      (state_vec[gi*W +: W]),
        .fire       (fire_vec[gi])
      );
    end
  endgenerate

  // Count from the unregistered fire vector so spike and spike_cnt land together.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_next = cnt_next + CW'(fire_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_reg     <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      spike_reg     <= fire_vec;
      cnt_reg       <= cnt_next;
      out_valid_reg <= bus.in_valid;
    end
  end

  assign bus.state     = state_vec;
  assign bus.spike     = spike_reg;
  assign bus.spike_cnt = cnt_reg;
  assign bus.out_valid = out_valid_reg;

endmodule
